memory_crossbar: RTL
====================

// Module: memory_crossbar
// PURPOSE
//  Parametrised successor to the fixed two-port memory router. N master ports (ins, data, DMA...)
//  reach M address-decoded slave regions; per-region round-robin replaces fixed data-over-ins priority.
//  Sits after fixed_memory_map (inputs are physical addresses) and ahead of the ram/rom instances.
//  Adds grant hold across slave busy, unmapped-address error reporting and a registered arbiter.
// PARAMETERS
//  N_M       2                      number of master ports
//  N_R       5                      number of slave regions
//  DN        32                     data width; mask width DN/8
//  SAN       23                     slave word-address width (offset[SAN+1:2])
//  R_BASE    {N_R{32'h0}}           packed N_R x 32 region base, inclusive
//  R_LIMIT   {N_R{32'h0}}           packed N_R x 32 region limit, exclusive
// PORTS
//  clk      in   1            clock, rising edge
//  rst_n    in   1            asynchronous active-low reset
//  m_addr   in   N_M*32       master physical byte address
//  m_read   in   N_M          master read request
//  m_write  in   N_M          master write request
//  m_mask   in   N_M*DN/8     master byte-write mask
//  m_din    in   N_M*DN       master write data
//  m_dout   out  N_M*DN       master read data
//  m_busy   out  N_M          master must hold request, retry next cycle
//  m_err    out  N_M          address hits no region (valid with request)
//  s_addr   out  N_R*SAN      slave word address = (m_addr - R_BASE)[SAN+1:2]
//  s_read   out  N_R          slave read strobe
//  s_write  out  N_R          slave write strobe
//  s_mask   out  N_R*DN/8     slave byte mask
//  s_din    out  N_R*DN       slave write data
//  s_dout   in   N_R*DN       slave read data
//  s_busy   in   N_R          slave not ready
// BEHAVIOUR
//  - Decode: region r hit when R_BASE[r] <= addr < R_LIMIT[r]; overlap -> lowest r wins. req = read|write.
//  - Per-region FSM IDLE/HOLD, round-robin pointer rr[r] (clog2(N_M) bits).
//  - IDLE: grant = first requesting master at or after rr[r] (wrap N_M-1 -> 0). Grant is combinational
//    in the same cycle. If s_busy[r]=0, access completes, rr[r] <= grant+1 mod N_M, stay IDLE;
//    if s_busy[r]=1, latch grant in owner[r], go HOLD.
//  - HOLD: owner[r] keeps the slave regardless of other requests. Leave to IDLE and advance rr[r] on
//    the cycle s_busy[r]=0. If owner drops its request, return to IDLE without advancing rr[r].
//  - Granted master: m_dout/m_busy from the slave. Requesting, non-granted masters: m_busy=1, m_dout='0.
//  - Ungranted slave: s_read=s_write=0, s_addr/s_din/s_mask from master rr[r]. A read+write request
//    drives both strobes; the slave gives write priority.
//  - Unmapped request: m_err=1, m_busy=0, m_dout='0 for that cycle, no slave strobe; otherwise m_err=0.
//  - Idle master (no request): m_busy=0, m_err=0, m_dout='0.
//  - rst_n low (async): all FSM IDLE, rr=0, owner=0. While rst_n is low, m_busy='1, s_read=s_write='0,
//    m_err='0, m_dout='0. Reset during HOLD abandons the access; the slave sees its strobes drop.
//  - Latency: zero added cycles when uncontended and s_busy=0; each contending master waits at most
//    N_M-1 grants.
//  - No combinational path from s_busy to the grant select except through the HOLD register.
// STRUCTURE
//  - memory_crossbar_pkg: region_t {base,limit}, arb_state_e {IDLE,HOLD}, function
//    rr_pick(req,ptr) -> idx,valid.
//  - Sub-module region_arbiter (one per region, generate loop): FSM, rr pointer, owner register.
//  - Top level: address decode, request vectors per region, output muxing.
// TESTING
//  - Reset: rst_n=0 with m_read=2'b11 -> m_busy=2'b11, s_read=0. Release -> rr=0.
//  - Single master, uncontended: N_M=2, m0 read 32'h1000_0010, s_busy=0 -> s_read[3]=1, s_addr=4,
//    m_busy[0]=0, same cycle.
//  - Contention: m0 and m1 both read region 0, s_busy=0, every cycle for 4 cycles -> grants
//    0,1,0,1. The loser sees m_busy=1.
//  - HOLD: m1 granted and s_busy=1 for 3 cycles while m0 also requests -> owner stays 1. m0 granted
//    the cycle after s_busy falls.
//  - Unmapped: m0 write 32'h7000_0000 -> m_err[0]=1, m_busy[0]=0, all s_write=0.
//  - Async reset mid-HOLD: rst_n pulses low between edges -> FSM IDLE immediately, strobes 0. After
//    release, a fresh request is granted normally.

Source files
------------

// File: rtl/memory_crossbar_pkg.sv
// rtl/memory_crossbar_pkg.sv - shared types and round-robin pick helper for the memory crossbar
package memory_crossbar_pkg;

  // Widest master count the shared pick helper supports, and its index width.
  localparam int MAX_M  = 16;
  localparam int MAX_MW = 4;

  typedef struct packed {
    logic [31:0] base;   // inclusive
    logic [31:0] limit;  // exclusive
  } region_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              valid;
    logic [MAX_MW-1:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping to the lowest set bit below ptr.
  function automatic pick_t rr_pick(input logic [MAX_M-1:0] req, input logic [MAX_MW-1:0] ptr);
    pick_t hi;
    pick_t lo;
    hi = '0;
    lo = '0;
    for (int i = MAX_M - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo = '{valid: 1'b1, idx: MAX_MW'(i)};
        if (MAX_MW'(i) >= ptr) begin
          hi = '{valid: 1'b1, idx: MAX_MW'(i)};
        end
      end
    end
    return hi.valid ? hi : lo;
  endfunction

endpackage

// File: rtl/memory_crossbar_if.sv
// rtl/memory_crossbar_if.sv - master-side and slave-side bus bundle of the memory crossbar
interface memory_crossbar_if #(
  parameter int N_M = 2,
  parameter int N_R = 5,
  parameter int DN  = 32,
  parameter int SAN = 23
);
  localparam int MW = DN / 8;

  logic [N_M*32-1:0]  m_addr;
  logic [N_M-1:0]     m_read;
  logic [N_M-1:0]     m_write;
  logic [N_M*MW-1:0]  m_mask;
  logic [N_M*DN-1:0]  m_din;
  logic [N_M*DN-1:0]  m_dout;
  logic [N_M-1:0]     m_busy;
  logic [N_M-1:0]     m_err;

  logic [N_R*SAN-1:0] s_addr;
  logic [N_R-1:0]     s_read;
  logic [N_R-1:0]     s_write;
  logic [N_R*MW-1:0]  s_mask;
  logic [N_R*DN-1:0]  s_din;
  logic [N_R*DN-1:0]  s_dout;
  logic [N_R-1:0]     s_busy;

  // Environment side: drives master requests and slave responses.
  modport master (
    output m_addr, m_read, m_write, m_mask, m_din,
    input  m_dout, m_busy, m_err,
    input  s_addr, s_read, s_write, s_mask, s_din,
    output s_dout, s_busy
  );

  // Crossbar side.
  modport slave (
    input  m_addr, m_read, m_write, m_mask, m_din,
    output m_dout, m_busy, m_err,
    output s_addr, s_read, s_write, s_mask, s_din,
    input  s_dout, s_busy
  );
endinterface

// File: rtl/memory_crossbar_region_arbiter.sv
// rtl/memory_crossbar_region_arbiter.sv - per-region round-robin arbiter with grant hold across slave busy
module memory_crossbar_region_arbiter
  import memory_crossbar_pkg::*;
#(
  parameter int N_M = 2,
  localparam int RW = (N_M > 1) ? $clog2(N_M) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N_M-1:0] req,
  input  logic           s_busy,
  output logic           grant_valid,
  output logic [RW-1:0]  grant_idx    // equals rr pointer when nothing is granted
);

  arb_state_e        state_q, state_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic [RW-1:0]     owner_q, owner_d;
  logic [MAX_M-1:0]  req_ext;
  pick_t             pick;
  logic [RW-1:0]     pick_idx;
  logic              unused_pick;

  function automatic logic [RW-1:0] wrap_inc(input logic [RW-1:0] x);
    if (x == RW'(N_M - 1)) return '0;
    return x + 1'b1;
  endfunction

  // Round-robin candidate from the registered pointer only.
  always_comb begin
    req_ext = '0;
    req_ext[N_M-1:0] = req;
    pick = rr_pick(req_ext, MAX_MW'(rr_q));
  end

  assign pick_idx    = pick.idx[RW-1:0];
  assign unused_pick = ^pick.idx;

  // Grant select and next state; s_busy only reaches the grant through state_q/owner_q.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    grant_valid = 1'b0;
    grant_idx   = rr_q;
    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          grant_valid = 1'b1;
          grant_idx   = pick_idx;
          if (s_busy) begin
            owner_d = pick_idx;
            state_d = HOLD;
          end else begin
            rr_d = wrap_inc(pick_idx);
          end
        end
      end
      HOLD: begin
        if (req[owner_q]) begin
          grant_valid = 1'b1;
          grant_idx   = owner_q;
          if (!s_busy) begin
            rr_d    = wrap_inc(owner_q);
            state_d = IDLE;
          end
        end else begin
          // Owner abandoned the access: release without advancing the pointer.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: rtl/memory_crossbar.sv
// rtl/memory_crossbar.sv - N-master to M-region address-decoded crossbar with per-region round-robin
module memory_crossbar
  import memory_crossbar_pkg::*;
#(
  parameter int             N_M     = 2,
  parameter int             N_R     = 5,
  parameter int             DN      = 32,
  parameter int             SAN     = 23,
  parameter logic [N_R*32-1:0] R_BASE  = {N_R{32'h0}},
  parameter logic [N_R*32-1:0] R_LIMIT = {N_R{32'h0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  memory_crossbar_if.slave bus
);

  localparam int MW  = DN / 8;
  localparam int RW  = (N_M > 1) ? $clog2(N_M) : 1;
  localparam int RIW = (N_R > 1) ? $clog2(N_R) : 1;

  region_t          region_map [N_R];
  logic [N_M-1:0]   m_req;
  logic [N_M-1:0]   m_hit;
  logic [RIW-1:0]   m_sel      [N_M];
  logic [N_M-1:0]   rreq       [N_R];
  logic [N_R-1:0]   gnt_valid;
  logic [RW-1:0]    gnt_idx    [N_R];
  logic [SAN+1:0]   s_off      [N_R];

  assign m_req = bus.m_read | bus.m_write;

  for (genvar r = 0; r < N_R; r++) begin : g_region
    logic unused_off;

    assign region_map[r] = '{base: R_BASE[r*32 +: 32], limit: R_LIMIT[r*32 +: 32]};
    assign unused_off    = ^s_off[r][1:0];

    memory_crossbar_region_arbiter #(.N_M(N_M)) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (rreq[r]),
      .s_busy      (bus.s_busy[r]),
      .grant_valid (gnt_valid[r]),
      .grant_idx   (gnt_idx[r])
    );
  end

  // Address decode: scan high to low so the lowest overlapping region wins.
  always_comb begin
    for (int m = 0; m < N_M; m++) begin
      m_hit[m] = 1'b0;
      m_sel[m] = '0;
      for (int r = N_R - 1; r >= 0; r--) begin
        if (bus.m_addr[m*32 +: 32] >= region_map[r].base &&
            bus.m_addr[m*32 +: 32] <  region_map[r].limit) begin
          m_hit[m] = 1'b1;
          m_sel[m] = RIW'(r);
        end
      end
    end
  end

  // Per-region request vectors from mapped, requesting masters.
  always_comb begin
    for (int r = 0; r < N_R; r++) begin
      for (int m = 0; m < N_M; m++) begin
        rreq[r][m] = m_req[m] & m_hit[m] & (m_sel[m] == RIW'(r));
      end
    end
  end

  // Slave side: route the granted master (or the rr pointer's master when idle).
  always_comb begin
    bus.s_addr  = '0;
    bus.s_read  = '0;
    bus.s_write = '0;
    bus.s_mask  = '0;
    bus.s_din   = '0;
    for (int r = 0; r < N_R; r++) begin
      s_off[r] = bus.m_addr[gnt_idx[r]*32 +: (SAN + 2)] - region_map[r].base[SAN+1:0];
      bus.s_addr[r*SAN +: SAN] = s_off[r][SAN+1:2];
      bus.s_mask[r*MW +: MW]   = bus.m_mask[gnt_idx[r]*MW +: MW];
      bus.s_din[r*DN +: DN]    = bus.m_din[gnt_idx[r]*DN +: DN];
      bus.s_read[r]  = rst_n & gnt_valid[r] & bus.m_read[gnt_idx[r]];
      bus.s_write[r] = rst_n & gnt_valid[r] & bus.m_write[gnt_idx[r]];
    end
  end

  // Master side: busy/err/read data per master, forced busy while in reset.
  always_comb begin
    bus.m_busy = '0;
    bus.m_err  = '0;
    bus.m_dout = '0;
    for (int m = 0; m < N_M; m++) begin
      if (!rst_n) begin
        bus.m_busy[m] = 1'b1;
      end else if (m_req[m]) begin
        if (!m_hit[m]) begin
          bus.m_err[m] = 1'b1;
        end else if (gnt_valid[m_sel[m]] && gnt_idx[m_sel[m]] == RW'(m)) begin
          bus.m_busy[m] = bus.s_busy[m_sel[m]];
          bus.m_dout[m*DN +: DN] = bus.s_dout[m_sel[m]*DN +: DN];
        end else begin
          bus.m_busy[m] = 1'b1;
        end
      end
    end
  end

endmodule
